// File: rtl/neural_network.sv
// Fixed-point neuron: weight memory, activation buffer and a single MAC that
// accumulates one term per enabled clock and closes out with ReLU + saturation.
module neural_network #(
    parameter int unsigned LAYER_SIZE  = 4,
    parameter int unsigned LAYER_DEPTH = 4,
    parameter int unsigned BIT_SIZE    = 16,
    localparam int unsigned LW = (LAYER_DEPTH > 1) ? $clog2(LAYER_DEPTH) : 1,
    localparam int unsigned NW = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       weight_write_enable,
    input  logic                       input_write_enable,
    input  logic                       input_select,
    input  logic [LW-1:0]              layer,
    input  logic [NW-1:0]              node,
    input  logic signed [BIT_SIZE-1:0] x,
    output logic signed [BIT_SIZE-1:0] y,
    output logic signed [BIT_SIZE-1:0] y_mem
);

    localparam int unsigned FRAC     = BIT_SIZE / 2;
    localparam int unsigned PW       = 2 * BIT_SIZE;
    localparam int unsigned AW       = PW + NW;
    localparam int unsigned LAST_IDX = LAYER_SIZE - 1;

    localparam logic [LW:0]   DEPTH_LIM = LAYER_DEPTH[LW:0];
    localparam logic [NW:0]   SIZE_LIM  = LAYER_SIZE[NW:0];
    localparam logic [NW-1:0] LAST_NODE = LAST_IDX[NW-1:0];

    localparam logic signed [AW-1:0] Y_MAX =
        {{(AW - BIT_SIZE + 1){1'b0}}, {(BIT_SIZE - 1){1'b1}}};

    logic signed [BIT_SIZE-1:0] w_mem [LAYER_DEPTH][LAYER_SIZE];
    logic signed [BIT_SIZE-1:0] a_mem [LAYER_SIZE];

    logic                       layer_ok;
    logic                       node_ok;
    logic signed [BIT_SIZE-1:0] w_rd;
    logic signed [BIT_SIZE-1:0] a_rd;
    logic signed [BIT_SIZE-1:0] operand;
    logic signed [PW-1:0]       op_ext;
    logic signed [PW-1:0]       w_ext;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       term;
    logic signed [AW-1:0]       term_ext;
    logic signed [AW-1:0]       sum;
    logic                       mac_en;
    logic                       last_node;

    logic signed [AW-1:0]       acc_q, acc_d;
    logic signed [BIT_SIZE-1:0] y_q, y_d;

    // Addresses beyond the parameterised range are dropped on write and read as 0.
    assign layer_ok = {1'b0, layer} < DEPTH_LIM;
    assign node_ok  = {1'b0, node} < SIZE_LIM;

    always_comb begin
        w_rd = '0;
        if (layer_ok && node_ok) begin
            w_rd = w_mem[layer][node];
        end
    end

    always_comb begin
        a_rd = '0;
        if (node_ok) begin
            a_rd = a_mem[node];
        end
    end

    assign y_mem = a_rd;

    // Memories are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (weight_write_enable && layer_ok && node_ok) begin
            w_mem[layer][node] <= x;
        end
    end

    always_ff @(posedge clk) begin
        if (input_write_enable && node_ok) begin
            a_mem[node] <= x;
        end
    end

    assign mac_en    = !weight_write_enable && !input_write_enable;
    assign last_node = (node == LAST_NODE);
    assign operand   = input_select ? x : a_rd;

    // Full-width signed product, then drop F fractional bits with floor rounding.
    assign op_ext   = {{BIT_SIZE{operand[BIT_SIZE-1]}}, operand};
    assign w_ext    = {{BIT_SIZE{w_rd[BIT_SIZE-1]}}, w_rd};
    assign prod     = op_ext * w_ext;
    assign term     = prod >>> FRAC;
    assign term_ext = {{NW{term[PW-1]}}, term};
    assign sum      = acc_q + term_ext;

    function automatic logic signed [BIT_SIZE-1:0] relu_sat(input logic signed [AW-1:0] v);
        if (v[AW-1]) begin
            return '0;
        end else if (v > Y_MAX) begin
            return Y_MAX[BIT_SIZE-1:0];
        end else begin
            return v[BIT_SIZE-1:0];
        end
    endfunction

    always_comb begin
        acc_d = acc_q;
        y_d   = y_q;
        if (mac_en) begin
            if (last_node) begin
                acc_d = '0;
                y_d   = relu_sat(sum);
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_neural_network.sv
// Directed bench for neural_network: arithmetic reference model compared every
// cycle, plus hand-computed literal results for each scenario.
module tb_neural_network;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               weight_write_enable = 1'b0;
    logic               input_write_enable = 1'b0;
    logic               input_select = 1'b0;
    logic [1:0]         layer = '0;
    logic [1:0]         node = '0;
    logic signed [15:0] x = '0;
    logic signed [15:0] y;
    logic signed [15:0] y_mem;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    neural_network #(
        .LAYER_SIZE (4),
        .LAYER_DEPTH(4),
        .BIT_SIZE   (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .weight_write_enable(weight_write_enable),
        .input_write_enable (input_write_enable),
        .input_select       (input_select),
        .layer              (layer),
        .node               (node),
        .x                  (x),
        .y                  (y),
        .y_mem              (y_mem)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on arrays.
    int     w_m [4][4];
    int     a_m [4];
    bit     a_known [4];
    longint m_acc = 0;
    longint m_y = 0;
    longint m_term;
    longint m_tot;
    int     m_op;

    initial begin
        for (int i = 0; i < 4; i++) begin
            a_known[i] = 1'b0;
            a_m[i] = 0;
            for (int j = 0; j < 4; j++) w_m[i][j] = 0;
        end
    end

    always @(posedge clk) begin
        if (weight_write_enable) w_m[layer][node] = int'(x);
        if (input_write_enable) begin
            a_m[node] = int'(x);
            a_known[node] = 1'b1;
        end
        if (!rst) begin
            m_acc = 0;
            m_y = 0;
        end else if (!weight_write_enable && !input_write_enable) begin
            m_op = input_select ? int'(x) : a_m[node];
            m_term = (longint'(m_op) * longint'(w_m[layer][node])) >>> 8;
            m_tot = m_acc + m_term;
            if (node == 2'd3) begin
                if (m_tot < 0) m_y = 0;
                else if (m_tot > 32767) m_y = 32767;
                else m_y = m_tot;
                m_acc = 0;
            end else begin
                m_acc = m_tot;
            end
        end
    end

    always @(negedge rst) begin
        m_acc = 0;
        m_y = 0;
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("y_model", longint'(y), m_y);
            if (a_known[node]) check("y_mem_model", longint'(y_mem), longint'(a_m[node]));
        end
    end

    task automatic drive(input logic we, input logic ie, input logic sel,
                         input int l, input int n, input int v);
        weight_write_enable = we;
        input_write_enable  = ie;
        input_select        = sel;
        layer               = 2'(l);
        node                = 2'(n);
        x                   = 16'(v);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        #1 check("reset_y", longint'(y), 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // Weights for layers 0..2.
        for (int n = 0; n < 4; n++) drive(1, 0, 0, 0, n, 256);
        for (int n = 0; n < 4; n++) drive(1, 0, 0, 1, n, 256);
        for (int n = 0; n < 4; n++) drive(1, 0, 0, 2, n, 32767);
        check("idle_y", longint'(y), 0);

        // Direct path.
        for (int n = 0; n < 4; n++) drive(0, 0, 1, 0, n, 256 * (n + 1));
        check("direct_y", longint'(y), 2560);

        // ReLU clamps negative sum.
        drive(0, 0, 1, 1, 0, -256);
        drive(0, 0, 1, 1, 1, -512);
        drive(0, 0, 1, 1, 2, 0);
        drive(0, 0, 1, 1, 3, 256);
        check("relu_y", longint'(y), 0);

        // Saturation.
        for (int n = 0; n < 4; n++) drive(0, 0, 1, 2, n, 32767);
        check("sat_y", longint'(y), 32767);

        // Activation buffer, then layer-3 weights while reading y_mem back.
        for (int n = 0; n < 4; n++) drive(0, 1, 0, 0, n, 256 * (n + 1));
        for (int n = 0; n < 4; n++) begin
            drive(1, 0, 0, 3, n, 256);
            check("y_mem_readback", longint'(y_mem), 256 * (n + 1));
        end

        // Buffer path, out of order, with a gating write mid-sum.
        drive(0, 0, 0, 3, 2, 0);
        drive(0, 0, 0, 3, 0, 0);
        drive(0, 0, 0, 3, 1, 0);
        drive(1, 0, 0, 1, 0, 256);
        check("gated_y_hold", longint'(y), 32767);
        drive(0, 0, 0, 3, 3, 0);
        check("buffer_y", longint'(y), 2560);

        // Mid-sum reset discards partial terms but keeps memories.
        drive(0, 0, 1, 0, 0, 256);
        drive(0, 0, 1, 0, 1, 512);
        rst = 1'b0;
        #1;
        check("midreset_y", longint'(y), 0);
        check("midreset_y_mem", longint'(y_mem), 512);
        #1 rst = 1'b1;
        for (int n = 0; n < 4; n++) drive(0, 0, 1, 0, n, 256 * (n + 1));
        check("rerun_y", longint'(y), 2560);

        // Simultaneous weight and buffer write, then a buffer-path sum using both.
        drive(1, 1, 0, 0, 0, 512);
        check("dual_write_y_mem", longint'(y_mem), 512);
        check("dual_write_y_hold", longint'(y), 2560);
        for (int n = 0; n < 4; n++) drive(0, 0, 0, 0, n, 0);
        check("dual_sum_y", longint'(y), 3328);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
